// File: rtl/ball_engine.sv
// Breakout ball engine: position, velocity, pixel-sampled collisions,
// serve/launch, lives and game-over. Motion advances once per frame tick.
module ball_engine #(
    parameter int BALL_SIZE = 8,
    parameter int STEP      = 2,
    parameter int LIVES     = 3,
    parameter int FRAME_ROW = 500,
    parameter int MISS_ROW  = 470,
    parameter int SERVE_Y   = 432,
    parameter int SERVE_DX  = 28
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [8:0] row,
    input  logic [9:0] col,
    input  logic [9:0] paddle_left,
    input  logic       wall_px,
    input  logic       paddle_px,
    input  logic [4:0] brick_id,
    input  logic       launch,
    output logic       ball_px,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       brick_hit,
    output logic [4:0] brick_hit_id,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

    localparam logic [9:0]         RESET_X = 10'd261;
    localparam logic [8:0]         SERVE_Y9 = 9'(SERVE_Y);
    localparam logic [9:0]         SERVE_DX10 = 10'(SERVE_DX);
    localparam logic [10:0]        SIZE11 = 11'(BALL_SIZE);
    localparam logic [10:0]        HALF11 = 11'(BALL_SIZE / 2);
    localparam logic signed [11:0] STEP12 = 12'(STEP);
    localparam logic signed [11:0] X_LO = 12'sd40;
    localparam logic signed [11:0] X_HI = 12'sd582;
    localparam logic signed [11:0] Y_LO = 12'sd30;
    localparam logic signed [11:0] Y_HI = 12'(511 - BALL_SIZE);

    state_t      state, state_next;
    logic [8:0]  row_d;
    logic        tick;
    logic        dx_neg, dy_neg, dx_neg_new, dy_neg_new;
    logic        hit_t, hit_b, hit_l, hit_r;
    logic        brick_pending;
    logic [4:0]  pending_id;
    logic        launch_latch;
    logic        visible;
    logic        miss;
    logic [9:0]  serve_x;

    logic [10:0] col_e, row_e, bx_e, by_e;
    logic        at_top, at_bot, at_left, at_right, at_probe;
    logic        obstacle, brick_here;

    logic signed [11:0] x_sum, y_sum, x_clamp, y_clamp;

    assign tick = (row == 9'(FRAME_ROW)) && (row_d != 9'(FRAME_ROW));

    // Coordinates are widened so that a probe at -1 cannot alias a real pixel.
    assign col_e = {1'b0, col};
    assign row_e = {2'b00, row};
    assign bx_e  = {1'b0, ball_x};
    assign by_e  = {2'b00, ball_y};

    assign at_top   = (col_e == bx_e + HALF11) && (row_e == by_e - 11'd1);
    assign at_bot   = (col_e == bx_e + HALF11) && (row_e == by_e + SIZE11);
    assign at_left  = (col_e == bx_e - 11'd1)  && (row_e == by_e + HALF11);
    assign at_right = (col_e == bx_e + SIZE11) && (row_e == by_e + HALF11);
    assign at_probe = at_top | at_bot | at_left | at_right;

    assign brick_here = (brick_id != 5'd0);
    assign obstacle   = wall_px | paddle_px | brick_here;

    assign serve_x = paddle_left + SERVE_DX10;
    assign miss    = (ball_y >= 9'(MISS_ROW));

    assign ball_px = visible
                   && (col_e >= bx_e) && (col_e < bx_e + SIZE11)
                   && (row_e >= by_e) && (row_e < by_e + SIZE11);

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) row_d <= 9'd0;
        else          row_d <= row;
    end

    // Sticky probe flags and the first brick seen; samples on the tick cycle are dropped.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n || tick) begin
            hit_t         <= 1'b0;
            hit_b         <= 1'b0;
            hit_l         <= 1'b0;
            hit_r         <= 1'b0;
            brick_pending <= 1'b0;
            pending_id    <= 5'd0;
        end else begin
            if (at_top   && obstacle) hit_t <= 1'b1;
            if (at_bot   && obstacle) hit_b <= 1'b1;
            if (at_left  && obstacle) hit_l <= 1'b1;
            if (at_right && obstacle) hit_r <= 1'b1;
            if (at_probe && brick_here && !brick_pending) begin
                brick_pending <= 1'b1;
                pending_id    <= brick_id;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n || tick) launch_latch <= 1'b0;
        else if (launch)      launch_latch <= 1'b1;
    end

    // Flags are tested against the old direction so opposing hits cannot double-flip.
    always_comb begin
        dy_neg_new = dy_neg;
        if (hit_t && dy_neg)       dy_neg_new = 1'b0;
        else if (hit_b && !dy_neg) dy_neg_new = 1'b1;
        dx_neg_new = dx_neg;
        if (hit_l && dx_neg)       dx_neg_new = 1'b0;
        else if (hit_r && !dx_neg) dx_neg_new = 1'b1;

        x_sum = dx_neg_new ? ($signed({2'b00, ball_x}) - STEP12)
                           : ($signed({2'b00, ball_x}) + STEP12);
        y_sum = dy_neg_new ? ($signed({3'b000, ball_y}) - STEP12)
                           : ($signed({3'b000, ball_y}) + STEP12);

        x_clamp = x_sum;
        if (x_sum < X_LO)      x_clamp = X_LO;
        else if (x_sum > X_HI) x_clamp = X_HI;
        y_clamp = y_sum;
        if (y_sum < Y_LO)      y_clamp = Y_LO;
        else if (y_sum > Y_HI) y_clamp = Y_HI;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) state <= SERVE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SERVE: if (tick && launch_latch) state_next = PLAY;
            PLAY:  if (tick && miss)         state_next = (lives <= 2'd1) ? OVER : SERVE;
            OVER:  state_next = OVER;
            default: state_next = SERVE;
        endcase
    end

    always_comb begin
        game_over = (state == OVER);
        visible   = (state != OVER);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            ball_x       <= RESET_X;
            ball_y       <= SERVE_Y9;
            dx_neg       <= 1'b0;
            dy_neg       <= 1'b1;
            lives        <= 2'(LIVES);
            brick_hit    <= 1'b0;
            brick_hit_id <= 5'd0;
        end else begin
            brick_hit <= 1'b0;
            if (tick) begin
                case (state)
                    SERVE: begin
                        ball_x <= serve_x;
                        ball_y <= SERVE_Y9;
                        if (launch_latch) begin
                            dx_neg <= 1'b0;
                            dy_neg <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (miss) begin
                            if (lives != 2'd0) lives <= lives - 2'd1;
                            if (lives > 2'd1) begin
                                ball_x <= serve_x;
                                ball_y <= SERVE_Y9;
                            end
                        end else begin
                            dx_neg <= dx_neg_new;
                            dy_neg <= dy_neg_new;
                            ball_x <= 10'(x_clamp);
                            ball_y <= 9'(y_clamp);
                            if (brick_pending) begin
                                brick_hit    <= 1'b1;
                                brick_hit_id <= pending_id;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: drives row/col straight to probe pixels and
// to the frame row rather than sweeping a full VGA raster.
module tb_ball_engine;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [8:0] row;
    logic [9:0] col;
    logic [9:0] paddle_left;
    logic       wall_px, paddle_px, launch;
    logic [4:0] brick_id;
    logic       ball_px, brick_hit, game_over;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [4:0] brick_hit_id;
    logic [1:0] lives;

    int n_checks = 0;
    int n_fail   = 0;

    ball_engine dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .row          (row),
        .col          (col),
        .paddle_left  (paddle_left),
        .wall_px      (wall_px),
        .paddle_px    (paddle_px),
        .brick_id     (brick_id),
        .launch       (launch),
        .ball_px      (ball_px),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .brick_hit    (brick_hit),
        .brick_hit_id (brick_hit_id),
        .lives        (lives),
        .game_over    (game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Idle one cycle off the frame row, then present the frame row for the tick edge.
    task automatic frame_tick();
        wall_px = 1'b0; paddle_px = 1'b0; brick_id = 5'd0;
        row = 9'd0; col = 10'd0;
        cycle();
        row = 9'd500;
        cycle();
        row = 9'd0;
    endtask

    task automatic probe(input logic [8:0] r, input logic [9:0] c,
                         input logic w, input logic [4:0] b);
        row = r; col = c; wall_px = w; brick_id = b;
        cycle();
        wall_px = 1'b0; brick_id = 5'd0; row = 9'd0; col = 10'd0;
    endtask

    task automatic pixel(input logic [8:0] r, input logic [9:0] c,
                         input logic exp, input string tag);
        row = r; col = c;
        cycle();
        check(tag, 32'(ball_px), 32'(exp));
        row = 9'd0; col = 10'd0;
    endtask

    task automatic pulse_launch();
        launch = 1'b1;
        cycle();
        launch = 1'b0;
    endtask

    // Serve, bounce off a top obstacle, fall from y=434 to 470, then miss.
    task automatic serve_and_miss();
        pulse_launch();
        frame_tick();
        probe(9'd431, 10'd265, 1'b1, 5'd0);
        frame_tick();
        repeat (18) frame_tick();
        frame_tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n = 1'b0; row = 9'd0; col = 10'd0; paddle_left = 10'd233;
        wall_px = 1'b0; paddle_px = 1'b0; brick_id = 5'd0; launch = 1'b0;
        repeat (2) cycle();
        check("rst_x",      32'(ball_x), 261);
        check("rst_y",      32'(ball_y), 432);
        check("rst_lives",  32'(lives), 3);
        check("rst_over",   32'(game_over), 0);
        check("rst_hit",    32'(brick_hit), 0);
        check("rst_hit_id", 32'(brick_hit_id), 0);
        reset_n = 1'b1;
        cycle();

        repeat (3) frame_tick();
        check("serve_x",     32'(ball_x), 261);
        check("serve_y",     32'(ball_y), 432);
        check("serve_lives", 32'(lives), 3);
        pixel(9'd432, 10'd261, 1'b1, "px_tl");
        pixel(9'd439, 10'd268, 1'b1, "px_br");
        pixel(9'd435, 10'd260, 1'b0, "px_left_out");
        pixel(9'd435, 10'd269, 1'b0, "px_right_out");
        pixel(9'd431, 10'd264, 1'b0, "px_above_out");
        pixel(9'd440, 10'd264, 1'b0, "px_below_out");

        pulse_launch();
        frame_tick();
        check("launch_x", 32'(ball_x), 261);
        check("launch_y", 32'(ball_y), 432);
        frame_tick();
        check("move1_x", 32'(ball_x), 263);
        check("move1_y", 32'(ball_y), 430);

        repeat (159) frame_tick();
        check("run_x", 32'(ball_x), 581);
        check("run_y", 32'(ball_y), 112);
        frame_tick();
        check("clamp_x", 32'(ball_x), 582);
        check("clamp_y", 32'(ball_y), 110);

        probe(9'd114, 10'd590, 1'b1, 5'd0);
        frame_tick();
        check("wall_x", 32'(ball_x), 580);
        check("wall_y", 32'(ball_y), 108);

        probe(9'd107, 10'd584, 1'b0, 5'd5);
        probe(9'd116, 10'd584, 1'b0, 5'd9);
        frame_tick();
        check("brick_hit",    32'(brick_hit), 1);
        check("brick_id",     32'(brick_hit_id), 5);
        check("brick_x",      32'(ball_x), 578);
        check("brick_y",      32'(ball_y), 110);
        cycle();
        check("brick_hit_end",  32'(brick_hit), 0);
        check("brick_id_holds", 32'(brick_hit_id), 5);

        probe(9'd200, 10'd200, 1'b0, 5'd3);
        frame_tick();
        check("offprobe_hit", 32'(brick_hit), 0);
        check("offprobe_x",   32'(ball_x), 576);
        check("offprobe_y",   32'(ball_y), 112);

        repeat (179) frame_tick();
        check("fall_y", 32'(ball_y), 470);
        check("fall_x", 32'(ball_x), 218);
        frame_tick();
        check("miss1_lives", 32'(lives), 2);
        check("miss1_x",     32'(ball_x), 261);
        check("miss1_y",     32'(ball_y), 432);
        check("miss1_over",  32'(game_over), 0);

        serve_and_miss();
        check("miss2_lives", 32'(lives), 1);
        check("miss2_y",     32'(ball_y), 432);

        serve_and_miss();
        check("miss3_lives", 32'(lives), 0);
        check("miss3_over",  32'(game_over), 1);
        check("miss3_x",     32'(ball_x), 299);
        check("miss3_y",     32'(ball_y), 470);
        pixel(9'd472, 10'd300, 1'b0, "over_px");

        pulse_launch();
        frame_tick();
        frame_tick();
        check("over_hold_over",  32'(game_over), 1);
        check("over_hold_x",     32'(ball_x), 299);
        check("over_hold_y",     32'(ball_y), 470);
        check("over_hold_lives", 32'(lives), 0);

        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("rerst_lives", 32'(lives), 3);
        check("rerst_over",  32'(game_over), 0);
        check("rerst_x",     32'(ball_x), 261);
        check("rerst_y",     32'(ball_y), 432);
        cycle();

        pulse_launch();
        frame_tick();
        frame_tick();
        check("pre_x", 32'(ball_x), 263);
        check("pre_y", 32'(ball_y), 430);
        probe(9'd429, 10'd267, 1'b0, 5'd4);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        pulse_launch();
        frame_tick();
        check("midrst_hit1", 32'(brick_hit), 0);
        check("midrst_x1",   32'(ball_x), 261);
        check("midrst_y1",   32'(ball_y), 432);
        frame_tick();
        check("midrst_hit2", 32'(brick_hit), 0);
        check("midrst_x2",   32'(ball_x), 263);
        check("midrst_y2",   32'(ball_y), 430);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Owns the Breakout ball: position, velocity, collision response, serve/launch, lives and game-over.
- Sits beside bricks/paddle/wall. Consumes the VGA scan position (row, col) and the per-pixel object flags those blocks produce.
- Produces ball_px for the colour mixer, plus a one-cycle brick-hit event for the brick-state logic.
- Collisions are found by pixel sampling during the scan. Motion updates once per frame.

Parameters:
- BALL_SIZE, 8, ball square side in pixels.
- STEP, 2, pixels moved per axis per frame.
- LIVES, 3, lives loaded at reset (1..3).
- FRAME_ROW, 500, row value whose first occurrence per frame generates the frame tick; lies outside all visible objects.
- MISS_ROW, 470, ball_y at or above this value counts as a miss.
- SERVE_Y, 432, ball_y while serving (paddle top 440 − BALL_SIZE).
- SERVE_DX, 28, ball_x offset from paddle_left while serving.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- row  in  9  current VGA scan row.
- col  in  10  current VGA scan column.
- paddle_left  in  10  paddle left column, registered by the paddle block.
- wall_px  in  1  wall present at (row, col).
- paddle_px  in  1  paddle present at (row, col).
- brick_id  in  5  brick at (row, col); 0 = none.
- launch  in  1  one-cycle launch pulse (checkButton buttonPress==1 decode).
- ball_px  out  1  ball present at (row, col).
- ball_x  out  10  ball left column.
- ball_y  out  9  ball top row.
- brick_hit  out  1  one-cycle pulse: ball struck a brick this frame.
- brick_hit_id  out  5  id of struck brick; valid while brick_hit=1.
- lives  out  2  remaining lives.
- game_over  out  1  high in OVER state.

Behaviour:
- Reset (reset_n=0 at a CLOCK_50 edge), taking priority over everything else:
  - state=SERVE, ball_x=261, ball_y=SERVE_Y, dx=+STEP, dy=−STEP.
  - lives=LIVES, all hit flags and launch latch cleared.
  - brick_hit=0, brick_hit_id=0, game_over=0.
  - Reset mid-frame discards partially latched hits.
- Frame tick: row_d is row registered. tick=1 in the single cycle where row==FRAME_ROW and row_d!=FRAME_ROW. All state/position updates occur only on tick, except that hit-flag and launch latching occur every cycle.
- ball_px is combinational from registered position: 1 iff ball_x ≤ col < ball_x+BALL_SIZE and ball_y ≤ row < ball_y+BALL_SIZE and state≠OVER. There is no pipeline latency, matching the other object blocks.
- Probe pixels (positions are registered values; widths extended to 11 bits so −1 does not alias):
  - top (ball_x+4, ball_y−1)
  - bottom (ball_x+4, ball_y+BALL_SIZE)
  - left (ball_x−1, ball_y+4)
  - right (ball_x+BALL_SIZE, ball_y+4)
- obstacle = wall_px | paddle_px | (brick_id≠0).
  - When (row, col) equals a probe and obstacle=1, set the matching sticky flag hit_t/hit_b/hit_l/hit_r.
  - If brick_id≠0 at any probe and no brick is yet latched this frame, latch brick_id into a pending register. Only the first brick in scan order per frame is latched.
- On tick, flags and pending brick are cleared after use. Samples arriving in the tick cycle itself are dropped.
- launch: sticky latch set on pulse in any state. Consumed (cleared) on the next tick.
- States:
  - SERVE:
    - ball_x=paddle_left+SERVE_DX and ball_y=SERVE_Y on every tick.
    - If the launch latch is set at tick: dx=+STEP, dy=−STEP, go to PLAY.
  - PLAY, on tick, evaluated in this order:
    1. Miss: if ball_y ≥ MISS_ROW, lives−1. If the result is 0, go to OVER; else go to SERVE with ball placed at the serve position. No movement and no brick_hit this tick.
    2. Reflect: dy=+STEP if hit_t and dy<0; dy=−STEP if hit_b and dy>0; dx=+STEP if hit_l and dx<0; dx=−STEP if hit_r and dx>0. Opposing flags can therefore flip at most one direction per axis.
    3. Move: ball_x+=dx, ball_y+=dy using the new direction, clamped to ball_x∈[40, 582], ball_y∈[30, 511−BALL_SIZE].
    4. Brick: if a brick was latched, brick_hit=1 and brick_hit_id=id for the cycle after tick, then brick_hit returns to 0 and brick_hit_id holds.
  - OVER: game_over=1, ball_px=0, position frozen, launch ignored. Left only by reset.
- lives never underflows; OVER is entered when it reaches 0.

Test Plan:
- Reset then 3 frames with paddle_left=233, no launch -> ball_x=261, ball_y=432, lives=3, ball_px=1 exactly over col 261..268, row 432..439.
- launch pulse mid-frame -> at next tick state=PLAY; one tick later ball_x=263, ball_y=430.
- Ball moving up-right, wall_px=1 at right probe (ball_x=582 region) -> dx becomes −2 at next tick; dy unchanged; ball_x decreases by 2.
- brick_id=5 at top probe and brick_id=9 later in the same frame -> exactly one brick_hit pulse with brick_hit_id=5; dy flips to +2.
- ball_y forced ≥470 in PLAY with lives=1 -> at tick lives=0, game_over=1, ball_px=0; a subsequent launch has no effect; reset_n=0 restores lives=3, SERVE.
- reset_n=0 asserted mid-frame after hit_t was latched -> after release, the next tick shows no reflection and no brick_hit.
